fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Read-side consumer for the 32x8 synchronous FIFO. It pops bytes from the FIFO read port and serialises each one as an asynchronous UART frame on txd. The frame is: start bit, 8 data bits LSB first, an optional parity bit, then one stop bit. It sits between the FIFO's read/dataout/empty pins and the chip-level serial output pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

Ports:
clock  input  1  single system clock; all state changes on its rising edge.
resetN  input  1  asynchronous active-low reset.
txEnable  input  1  permits a new frame to start; sampled only in IDLE.
fifoEmpty  input  1  FIFO empty flag.
fifoRead  output  1  FIFO read request; high for exactly one cycle per byte.
fifoData  input  8  FIFO dataout; valid in the cycle after fifoRead was high.
txd  output  1  serial line; idle level is 1.
busy  output  1  high from the fifoRead cycle through the last stop-bit cycle.
frameDone  output  1  one-cycle pulse on the final cycle of the stop bit.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Reset values: txd=1, fifoRead=0, busy=0, frameDone=0, state=IDLE, counters=0, shift register=0.
- Reset asserted mid-frame: txd returns to 1 immediately. The byte in flight is discarded and the FIFO is not re-read.
- IDLE state:
  - If txEnable=1 and fifoEmpty=0, drive fifoRead=1 combinationally for this cycle and go to LOAD.
  - Otherwise stay in IDLE with fifoRead=0.
- LOAD state (1 cycle):
  - The FIFO registers dataout on the edge that ends the read cycle, so fifoData is valid here.
  - Latch fifoData into the 8-bit shift register, compute parity, go to START.
  - fifoRead=0.
- START state: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA state:
  - txd = shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
  - A 3-bit bit index runs 0..7.
  - After bit 7, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY state:
  - txd = XOR of the 8 data bits, inverted when PARITY_ODD=1.
  - Lasts CLKS_PER_BIT cycles, then go to STOP.
- STOP state:
  - txd=1 for CLKS_PER_BIT cycles.
  - frameDone=1 on the last cycle, then go to IDLE.
- Bit timer:
  - Down-counter of width clog2(CLKS_PER_BIT).
  - Loaded with CLKS_PER_BIT-1 on entry to every bit.
  - Bit ends in the cycle the counter reaches 0.
  - No drift is permitted across a frame.
- Frame length: (10+PARITY_EN)*CLKS_PER_BIT cycles of txd activity.
- Back-to-back frames: with the FIFO continuously non-empty and txEnable=1, consecutive start bits are separated by exactly 2 cycles of txd=1 (the IDLE read cycle plus LOAD).
- txEnable deasserted mid-frame: the current frame completes; no new read is issued.
- fifoEmpty is ignored outside IDLE. Exactly one pop per frame; the block never reads an empty FIFO.
- fifoData is ignored in every state except LOAD. The FIFO drives 0 when not reading, so sampling elsewhere would be wrong.
- busy = (state != IDLE) OR fifoRead.

Decomposition:
- Package fifo_uart_pkg holds:
  - the state enum {IDLE, LOAD, START, DATA, PARITY, STOP};
  - constants DATA_BITS=8, IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- One natural sub-module, uart_bit_timer:
  - parameter CLKS_PER_BIT;
  - inputs clock, resetN, load;
  - output bitEnd.
- The FSM, shift register and parity logic stay in fifo_uart_tx.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0; FIFO holds 0xA5; txEnable=1 -> one fifoRead pulse, then txd = 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles. frameDone pulses on cycle 40 after LOAD; busy falls the next cycle.
2. PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit = 1, frame length 44 cycles. Repeat with PARITY_ODD=1 -> parity bit = 0.
3. FIFO preloaded with 0x01, 0x02, 0x03 -> exactly 3 fifoRead pulses, each 2 cycles of txd=1 between stop bit and next start bit, fifoEmpty=1 afterwards, then no further reads.
4. Empty FIFO, txEnable=1 for 100 cycles -> fifoRead never asserted, txd=1, busy=0.
5. txEnable dropped during data bit 3 with 2 bytes queued -> current frame finishes intact, no second fifoRead until txEnable returns to 1.
6. resetN pulsed low during the DATA state -> txd=1 and busy=0 asynchronously. After release, the next queued byte is transmitted cleanly from its start bit.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the FIFO (slave) and its consumer (master).
interface fifo_uart_tx_if;
    import fifo_uart_pkg::*;

    logic                 fifoEmpty;
    logic                 fifoRead;
    logic [DATA_BITS-1:0] fifoData;

    modport master (output fifoRead, input fifoEmpty, input fifoData);
    modport slave  (input fifoRead, output fifoEmpty, output fifoData);

endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Per-bit down-counter: reload starts a bit, bitEnd flags its last cycle.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic resetN,
    input  logic load,
    output logic bitEnd
);

    localparam int             W      = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0]   RELOAD = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload and bitEnd coincide at bit boundaries, so bits never drift.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = RELOAD;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign bitEnd = (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and sends each as a UART frame on txd.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clock,
    input  logic                  resetN,
    fifo_uart_tx_if.master        fifo,
    input  logic                  txEnable,
    output logic                  txd,
    output logic                  busy,
    output logic                  frameDone
);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 par_q, par_d;
    logic                 rd_req;
    logic                 timer_load;
    logic                 bit_end;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clock  (clock),
        .resetN (resetN),
        .load   (timer_load),
        .bitEnd (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        par_d      = par_q;
        rd_req     = 1'b0;
        timer_load = 1'b0;
        txd        = IDLE_LEVEL;
        frameDone  = 1'b0;
        case (state_q)
            IDLE: begin
                if (txEnable && !fifo.fifoEmpty) begin
                    rd_req  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // fifoData is only meaningful in this cycle.
                shift_d    = fifo.fifoData;
                par_d      = (^fifo.fifoData) ^ (PARITY_ODD != 0);
                bit_idx_d  = '0;
                timer_load = 1'b1;
                state_d    = START;
            end
            START: begin
                txd = START_LEVEL;
                if (bit_end) begin
                    timer_load = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                txd = shift_q[0];
                if (bit_end) begin
                    timer_load = 1'b1;
                    shift_d    = shift_q >> 1;
                    bit_idx_d  = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'(DATA_BITS - 1))
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                txd = par_q;
                if (bit_end) begin
                    timer_load = 1'b1;
                    state_d    = STOP;
                end
            end
            STOP: begin
                txd = IDLE_LEVEL;
                if (bit_end) begin
                    frameDone = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
        end
    end

    // Gated by reset so a held-low reset never pops the FIFO.
    assign fifo.fifoRead = rd_req & resetN;
    assign busy          = (state_q != IDLE) | fifo.fifoRead;

    a_no_empty_read: assert property (@(posedge clock) disable iff (!resetN)
        fifo.fifoRead |-> !fifo.fifoEmpty);
    a_read_pulse: assert property (@(posedge clock) disable iff (!resetN)
        fifo.fifoRead |=> !fifo.fifoRead);
    a_done_idle_level: assert property (@(posedge clock) disable iff (!resetN)
        frameDone |-> txd);

endmodule
